// File: rtl/router_delay_xbar_pkg.sv
// Shared definitions for the delay-line crossbar router: flit width helpers,
// source port indices and the priority encoder used on crossbar selects.
package router_delay_xbar_pkg;

   localparam int EAST  = 0;
   localparam int SOUTH = 1;
   localparam int WEST  = 2;
   localparam int NORTH = 3;

   // ALU and TREG sit directly after the remote ports in the source list.
   localparam int ALU_T_OFS = 0;
   localparam int TREG_OFS  = 1;

   localparam int SEL_MAX_W = 32;

   function automatic int flit_width(input int data_width);
      return data_width + 1;
   endfunction

   function automatic int alu_index(input int num_remote);
      return num_remote + ALU_T_OFS;
   endfunction

   function automatic int treg_index(input int num_remote);
      return num_remote + TREG_OFS;
   endfunction

   function automatic int lowest_set(input logic [SEL_MAX_W-1:0] v);
      int idx;
      idx = 0;
      for (int i = SEL_MAX_W - 1; i >= 0; i--) begin
         if (v[i]) idx = i;
      end
      return idx;
   endfunction

   function automatic logic is_multi_hot(input logic [SEL_MAX_W-1:0] v);
      return (v & (v - 1'b1)) != '0;
   endfunction

endpackage

// File: rtl/router_delay_xbar_delay_line.sv
// Write-enabled shift register holding the last DEPTH captured flits of one port;
// q[0] is the newest stage.
module flit_delay_line #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 33
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         en,
   input  logic [WIDTH-1:0]             d,
   output logic [DEPTH-1:0][WIDTH-1:0]  q
);

   logic [DEPTH-1:0][WIDTH-1:0] r_stages;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_stages[0] <= '0;
      end else if (en) begin
         r_stages[0] <= d;
      end
   end

   genvar gi;
   generate
      for (gi = 1; gi < DEPTH; gi++) begin : g_stage
         always_ff @(posedge clk) begin
            if (reset) begin
               r_stages[gi] <= '0;
            end else if (en) begin
               r_stages[gi] <= r_stages[gi-1];
            end
         end
      end
   endgenerate

   assign q = r_stages;

endmodule

// File: rtl/router_delay_xbar.sv
// Per-PE router: remote flits pass through tapped delay lines, then a one-hot
// crossbar with ALU/TREG sources; multi-hot selects are flagged and counted.
module router_delay_xbar
   import router_delay_xbar_pkg::*;
#(
   parameter int DATA_WIDTH  = 32,
   parameter int NUM_REMOTE  = 4,
   parameter int NUM_OUT     = 7,
   parameter int DELAY_DEPTH = 2,
   parameter int OUT_REG     = 0,
   parameter int ERR_CNT_W   = 16
) (
   input  logic                                              clk,
   input  logic                                              reset,
   input  logic [NUM_REMOTE-1:0][DATA_WIDTH:0]               i__flit_in,
   input  logic [DATA_WIDTH:0]                               i__alu_out,
   input  logic [DATA_WIDTH:0]                               i__treg,
   input  logic [NUM_OUT-1:0][NUM_REMOTE+1:0]                i__xbar_sel,
   input  logic [NUM_REMOTE-1:0]                             i__reg_wen,
   input  logic [NUM_REMOTE-1:0][$clog2(DELAY_DEPTH+1)-1:0]  i__tap_sel,
   input  logic                                              i__stall,
   input  logic                                              i__err_clr,
   output logic [NUM_OUT-1:0][DATA_WIDTH:0]                  o__flit_out,
   output logic [NUM_OUT-1:0]                                o__sel_err,
   output logic [ERR_CNT_W-1:0]                              o__err_cnt
);

   localparam int FLIT_W   = flit_width(DATA_WIDTH);
   localparam int NUM_SRC  = NUM_REMOTE + 2;
   localparam int ALU_IDX  = alu_index(NUM_REMOTE);
   localparam int TREG_IDX = treg_index(NUM_REMOTE);

   logic [NUM_REMOTE-1:0][DELAY_DEPTH-1:0][FLIT_W-1:0] w_stages;
   logic [NUM_REMOTE-1:0][FLIT_W-1:0]                  w_tap;
   logic [NUM_SRC-1:0][FLIT_W-1:0]                     w_src;
   logic [NUM_OUT-1:0][FLIT_W-1:0]                     w_xbar;
   logic [NUM_OUT-1:0]                                 w_conflict;
   logic                                               w_any_conflict;

   logic [NUM_OUT-1:0]                                 r_sel_err;
   logic [ERR_CNT_W-1:0]                               r_err_cnt;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REMOTE; gi++) begin : g_port
         logic [FLIT_W-1:0] w_tap_sel_flit;

         flit_delay_line #(
            .DEPTH (DELAY_DEPTH),
            .WIDTH (FLIT_W)
         ) u_delay_line (
            .clk   (clk),
            .reset (reset),
            .en    (i__reg_wen[gi] & ~i__stall),
            .d     (i__flit_in[gi]),
            .q     (w_stages[gi])
         );

         // Tap 0 bypasses the line entirely; taps beyond the depth read as an empty flit.
         always_comb begin
            w_tap_sel_flit = '0;
            if (i__tap_sel[gi] == '0) begin
               w_tap_sel_flit = i__flit_in[gi];
            end else begin
               for (int k = 0; k < DELAY_DEPTH; k++) begin
                  if (int'(i__tap_sel[gi]) == k + 1) w_tap_sel_flit = w_stages[gi][k];
               end
            end
         end

         assign w_tap[gi] = w_tap_sel_flit;
      end
   endgenerate

   assign w_src[NUM_REMOTE-1:0] = w_tap;
   assign w_src[ALU_IDX]        = i__alu_out;
   assign w_src[TREG_IDX]       = i__treg;

   generate
      for (gi = 0; gi < NUM_OUT; gi++) begin : g_out
         logic [SEL_MAX_W-1:0] w_sel_ext;
         logic [FLIT_W-1:0]    w_routed;
         logic                 w_multi;
         int                   w_win;

         always_comb begin
            w_sel_ext              = '0;
            w_sel_ext[NUM_SRC-1:0] = i__xbar_sel[gi];
            w_win                  = lowest_set(w_sel_ext);
            w_multi                = is_multi_hot(w_sel_ext);
            w_routed               = '0;
            for (int s = 0; s < NUM_SRC; s++) begin
               if (i__xbar_sel[gi][s] && (s == w_win)) w_routed = w_src[s];
            end
         end

         assign w_xbar[gi]     = w_routed;
         assign w_conflict[gi] = w_multi;
      end
   endgenerate

   assign w_any_conflict = |w_conflict;

   // A clear coinciding with a conflict still records that conflict.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_sel_err <= '0;
         r_err_cnt <= '0;
      end else if (!i__stall) begin
         if (i__err_clr) begin
            r_sel_err <= w_conflict;
            r_err_cnt <= w_any_conflict ? ERR_CNT_W'(1) : '0;
         end else begin
            r_sel_err <= r_sel_err | w_conflict;
            if (w_any_conflict && (r_err_cnt != '1)) begin
               r_err_cnt <= r_err_cnt + 1'b1;
            end
         end
      end
   end

   assign o__sel_err = r_sel_err;
   assign o__err_cnt = r_err_cnt;

   generate
      if (OUT_REG != 0) begin : g_out_reg
         logic [NUM_OUT-1:0][FLIT_W-1:0] r_flit_out;

         always_ff @(posedge clk) begin
            if (reset) begin
               r_flit_out <= '0;
            end else if (!i__stall) begin
               r_flit_out <= w_xbar;
            end
         end

         assign o__flit_out = r_flit_out;
      end else begin : g_out_comb
         assign o__flit_out = w_xbar;
      end
   endgenerate

endmodule

// File: doc/router_delay_xbar.md
Name: router_delay_xbar

Overview:
- Parametrised successor of the HyCUBE per-PE router.
- Routes NUM_REMOTE neighbour flits plus the ALU and TREG flits through a one-hot crossbar to NUM_OUT outputs.
- Each remote input gets a DELAY_DEPTH-stage write-enabled delay line, replacing the single bypass register; a per-port tap select picks the live flit or any stored stage.
- Adds global stall, optional registered outputs, and crossbar-select conflict detection with sticky flags and a saturating conflict counter.

Parameters:
- DATA_WIDTH, 32, payload bits; flit width FLIT_W = DATA_WIDTH+1, valid bit in MSB.
- NUM_REMOTE, 4, neighbour input ports (E,S,W,N order).
- NUM_OUT, 7, crossbar outputs.
- DELAY_DEPTH, 2, register stages per remote input (>=1).
- OUT_REG, 0, 1 = outputs registered (+1 cycle latency).
- ERR_CNT_W, 16, conflict counter width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- i__flit_in  in  FLIT_W x NUM_REMOTE  neighbour flits
- i__alu_out  in  FLIT_W  ALU result flit, source index NUM_REMOTE
- i__treg  in  FLIT_W  TREG flit, source index NUM_REMOTE+1
- i__xbar_sel  in  (NUM_REMOTE+2) x NUM_OUT  per-output one-hot source select
- i__reg_wen  in  NUM_REMOTE  per-port delay-line shift enable
- i__tap_sel  in  $clog2(DELAY_DEPTH+1) x NUM_REMOTE  0 = live input, t = stage t-1
- i__stall  in  1  freeze all state
- i__err_clr  in  1  clear sticky flags and counter
- o__flit_out  out  FLIT_W x NUM_OUT  routed flits
- o__sel_err  out  NUM_OUT  sticky multi-hot select flag per output
- o__err_cnt  out  ERR_CNT_W  saturating count of cycles with any conflict

Behaviour:
- Reset (synchronous, priority over all else): all delay stages, output registers, o__sel_err and o__err_cnt go to 0. With OUT_REG=1, o__flit_out reads 0 on the cycle after reset is sampled. With OUT_REG=0, o__flit_out tracks the inputs combinationally.
- Delay line, port j, when i__reg_wen[j] & ~i__stall at posedge:
  - stage0 <= i__flit_in[j];
  - stage k <= stage k-1.
  - The flit is captured regardless of its valid bit.
  - Otherwise stages hold.
- Tap mux, port j:
  - tap 0 gives i__flit_in[j] (combinational bypass);
  - tap t in 1..DELAY_DEPTH gives stage t-1;
  - tap > DELAY_DEPTH gives an all-zero flit.
- Crossbar, output o:
  - sel zero: all-zero flit (valid=0).
  - sel one-hot: the chosen source. Remote sources go through their tap mux; ALU/TREG are always live.
  - sel multi-hot: lowest set index wins; conflict raised for o.
- Conflict bookkeeping, on a non-stalled cycle:
  - o__sel_err[o] is set if output o conflicts.
  - o__err_cnt increments, saturating at all-ones, if any output conflicts.
  - i__err_clr clears flags and counter. In the same cycle as a conflict, the new conflict still sets its flag and the counter loads 1.
  - During stall, flags and counter hold.
- Output register (OUT_REG=1): loads the crossbar result when ~i__stall and holds when stalled. Latency is 1 cycle from select/input to output.
- Stall: stage shifts, output registers and error state all freeze. The combinational paths stay live: the live tap, and the whole crossbar when OUT_REG=0.
- Reset asserted mid-stream discards all stored flits; the first post-reset shift refills stage0 only.

Decomposition:
- SMARTPkg (shared) holds:
  - FlitFixed-compatible width helpers;
  - port index constants EAST/SOUTH/WEST/NORTH/ALU_T/TREG, generalised as NUM_REMOTE+0/+1;
  - a function returning the lowest-set-bit index for the onehot priority encode.
- Sub-module flit_delay_line: parameters DEPTH and WIDTH; ports clk, reset, en, d, and a packed array q of all stages. Instantiated NUM_REMOTE times.
- Crossbar, tap mux and error logic stay in the top module.

Test Plan:
- Reset, then flit_in[0]=33'h1_0000_00AA, sel[0]=1<<0, tap0=0 (OUT_REG=0) -> o__flit_out[0]=33'h1_0000_00AA in the same cycle; all other outputs 0.
- Delay line (DELAY_DEPTH=2):
  - drive flit_in[1] = A, B on consecutive cycles with reg_wen[1]=1, then set reg_wen[1]=0, sel[2]=1<<1;
  - tap=1 -> output B;
  - tap=2 -> output A;
  - tap=3 -> output 0;
  - values hold for 5 idle cycles.
- Stall: i__stall=1 with reg_wen=4'hF for 3 cycles while inputs change -> stages unchanged. OUT_REG=1 output frozen at its pre-stall value, then updates 1 cycle after stall drops.
- Conflict:
  - sel[3]=(1<<ALU)|(1<<1) -> output equals the port-1 tap, o__sel_err=7'b0001000, err_cnt=1;
  - held 3 more cycles -> err_cnt=4;
  - err_clr with conflict still present -> err_cnt=1, flag stays set;
  - counter forced near max -> saturates at 16'hFFFF.
- Reset mid-operation: fill both stages, assert reset one cycle -> tap1/tap2 read 0, sel_err=0, err_cnt=0. With OUT_REG=1, outputs read 0 the following cycle.
